ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single 32K x 8 async SRAM between the 6502-side request port (fed by the memory map /
//  synchronised CPU strobes) and the Mary video fetch port. Arbitrates, sequences SETUP/STROBE/HOLD
//  SRAM timing on clk, returns read data with a one-cycle ack. Sits between memory map/Mary and SRAM pins.
// PARAMETERS
//  ADDR_W       15  SRAM address width (0x0000-0x7FFF)
//  DATA_W       8   SRAM data width
//  WAIT_STATES  1   extra STROBE cycles beyond the first (>=0)
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  cpu_req      in   1       CPU transaction request (level)
//  cpu_we       in   1       1 = write, 0 = read; stable while cpu_req high
//  cpu_addr     in   ADDR_W  CPU address; stable while cpu_req high
//  cpu_wdata    in   DATA_W  CPU write data; stable while cpu_req high
//  cpu_ack      out  1       one-cycle completion pulse
//  cpu_rdata    out  DATA_W  read data, valid with cpu_ack, held until next CPU read ack
//  vid_req      in   1       video fetch request (read-only, level)
//  vid_addr     in   ADDR_W  video address; stable while vid_req high
//  vid_ack      out  1       one-cycle completion pulse
//  vid_rdata    out  DATA_W  read data, valid with vid_ack, held until next video ack
//  sram_addr    out  ADDR_W  SRAM address pins
//  sram_dq_o    out  DATA_W  SRAM write data
//  sram_dq_oe   out  1       1 = drive sram_dq_o onto bus
//  sram_dq_i    in   DATA_W  SRAM read data
//  sram_ce_n    out  1       chip enable, active low
//  sram_oe_n    out  1       output enable, active low
//  sram_we_n    out  1       write enable, active low
//  busy         out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, sram_addr=0,
//   sram_dq_o=0, cpu_ack=vid_ack=0, cpu_rdata=vid_rdata=0, busy=0, last-grant=VID. Reset mid-access
//   deasserts all strobes immediately; the interrupted transaction is dropped, no ack issued.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. All outputs registered.
//   IDLE: any req -> pick winner, latch addr/we/wdata/owner, -> SETUP. No req -> stay, strobes high.
//   SETUP (1 cyc): ce_n=0, addr driven; read: oe_n=0; write: dq_oe=1, we_n=1.
//   STROBE (WAIT_STATES+1 cyc): write: we_n=0; read: oe_n=0; down-counter, width max(1,$clog2(WAIT_STATES+1)).
//   HOLD (1 cyc): we_n=1 (write data still driven); reads capture sram_dq_i on STROBE->HOLD edge.
//   HOLD -> IDLE: owner ack=1 for exactly one cycle, rdata updated (reads only); ce_n/oe_n=1, dq_oe=0.
//  Latency: req sampled at edge N -> ack high in cycle following edge N+WAIT_STATES+3 (W=1: N+4).
//  Back-to-back: req still high in IDLE cycle carrying ack -> new transaction starts; one idle cycle
//   between accesses, so we_n never has consecutive low cycles across transactions.
//  Requester must drop req in the ack cycle if it wants no further transaction.
//  Simultaneous req: default fixed priority CPU > VID. Requests not granted wait; nothing is lost.
//  Write to video port impossible (no vid_we); cpu_rdata unchanged on write ack.
//  Req dropped mid-transaction: transaction completes, ack still issued.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous req, grant the requester NOT in last-grant;
//   last-grant updates on every grant. Undefined: fixed CPU priority, last-grant register not built.
// STRUCTURE
//  Package ram_arb_pkg: state enum (ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD), owner constants
//   OWN_CPU=1'b0, OWN_VID=1'b1.
//  Sub-module ram_arb_pick: combinational winner select (cpu_req, vid_req, last_grant -> grant, owner).
// TESTING
//  1 CPU read 0x1234, dq_i=0xA5, W=1 -> oe_n low 3 cyc, cpu_ack 1 cyc at N+4, cpu_rdata=0xA5.
//  2 CPU write 0x7FFF<=0x3C -> we_n low exactly W+1 cyc, dq_oe spans SETUP..HOLD, dq_o=0x3C, no rdata change.
//  3 cpu_req+vid_req same edge, macro off -> CPU granted first, VID acked 5 cyc later; macro on with
//     last-grant=CPU -> VID first.
//  4 vid_req held continuously, 3 reads of 0x0100/0x0101/0x0102 -> vid_ack every 5 cyc (W=1), idle gap kept.
//  5 reset_n low during STROBE of write -> we_n/ce_n=1, dq_oe=0 same cycle, no ack after release.
//  6 WAIT_STATES=0 and =3 -> STROBE 1 / 4 cycles, ack at N+3 / N+6.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: FSM state encodings and owner codes shared by the SRAM arbiter
package ram_arb_pkg;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_VID = 1'b1;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select; a tie goes to the side that did not win last
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic cpu_req,
   input  logic vid_req,
   input  logic last_grant,
   output logic grant,
   output logic owner
);
   // With last_grant pinned to VID this degenerates to fixed CPU priority
   always_comb begin
      grant = cpu_req | vid_req;
      owner = (cpu_req && vid_req) ? ~last_grant : (vid_req ? OWN_VID : OWN_CPU);
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one async SRAM between CPU and video ports; RAM_ARB_ROUND_ROBIN_EN enables round-robin tie-break
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              busy
);
   localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              owner, we, grant, pick_owner, last_grant, start_we;
   logic [DATA_W-1:0] rd_buf;

   ram_arb_pick u_pick (
      .cpu_req    (cpu_req),
      .vid_req    (vid_req),
      .last_grant (last_grant),
      .grant      (grant),
      .owner      (pick_owner)
   );

   assign start_we = (pick_owner == OWN_CPU) && cpu_we;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // Remember the most recent winner so the next tie goes to the other side
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) last_grant <= OWN_VID;
      else if (state == ST_IDLE && grant) last_grant <= pick_owner;
`else
   assign last_grant = OWN_VID;
`endif

   // Access sequencer: every SRAM pin and handshake output comes straight from a flop
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         owner      <= OWN_CPU;
         we         <= 1'b0;
         rd_buf     <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         cpu_ack    <= 1'b0;
         vid_ack    <= 1'b0;
         cpu_rdata  <= '0;
         vid_rdata  <= '0;
         busy       <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         vid_ack <= 1'b0;
         case (state)
            ST_IDLE: if (grant) begin
               state      <= ST_SETUP;
               busy       <= 1'b1;
               owner      <= pick_owner;
               we         <= start_we;
               sram_addr  <= (pick_owner == OWN_VID) ? vid_addr : cpu_addr;
               if (start_we) sram_dq_o <= cpu_wdata;
               sram_dq_oe <= start_we;
               sram_ce_n  <= 1'b0;
               sram_oe_n  <= start_we;
            end
            ST_SETUP: begin
               state     <= ST_STROBE;
               cnt       <= CNT_W'(WAIT_STATES);
               sram_we_n <= !we;
            end
            ST_STROBE: if (cnt == '0) begin
               state     <= ST_HOLD;
               sram_we_n <= 1'b1;
               sram_oe_n <= 1'b1;
               if (!we) rd_buf <= sram_dq_i;
            end else cnt <= cnt - 1'b1;
            default: begin
               state      <= ST_IDLE;
               busy       <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               cpu_ack    <= (owner == OWN_CPU);
               vid_ack    <= (owner == OWN_VID);
               if (!we && owner == OWN_CPU) cpu_rdata <= rd_buf;
               if (owner == OWN_VID) vid_rdata <= rd_buf;
            end
         endcase
      end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of the SRAM arbiter at WAIT_STATES 0, 1 and 3 sharing one stimulus
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
   logic [14:0] cpu_addr = '0, vid_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack_a [3], vid_ack_a [3], sram_dq_oe_a [3], sram_ce_n_a [3], sram_oe_n_a [3], sram_we_n_a [3], busy_a [3];
   logic [7:0]  cpu_rdata_a [3], vid_rdata_a [3], sram_dq_o_a [3], sram_dq_i_a [3];
   logic [14:0] sram_addr_a [3];
   int          vectors = 0, miscompares = 0;
   int          lat [3], oe_lo [3], we_lo [3], dqoe [3], ack_n [3];
   logic [7:0]  dq_seen;
   logic [14:0] addr_seen;

   always #5 clk = ~clk;

   // Index 0: WAIT_STATES=0, index 1: WAIT_STATES=1 (main), index 2: WAIT_STATES=3
   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign sram_dq_i_a[g] = sram_addr_a[g][7:0] ^ 8'h91;
      ram_arbiter #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .cpu_req    (cpu_req),
         .cpu_we     (cpu_we),
         .cpu_addr   (cpu_addr),
         .cpu_wdata  (cpu_wdata),
         .cpu_ack    (cpu_ack_a[g]),
         .cpu_rdata  (cpu_rdata_a[g]),
         .vid_req    (vid_req),
         .vid_addr   (vid_addr),
         .vid_ack    (vid_ack_a[g]),
         .vid_rdata  (vid_rdata_a[g]),
         .sram_addr  (sram_addr_a[g]),
         .sram_dq_o  (sram_dq_o_a[g]),
         .sram_dq_oe (sram_dq_oe_a[g]),
         .sram_dq_i  (sram_dq_i_a[g]),
         .sram_ce_n  (sram_ce_n_a[g]),
         .sram_oe_n  (sram_oe_n_a[g]),
         .sram_we_n  (sram_we_n_a[g]),
         .busy       (busy_a[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One CPU access on all three instances; req drops at the first ack, slower ones must still finish
   task automatic txn(input logic w, input logic [14:0] a, input logic [7:0] d);
      cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = d;
      dq_seen = '0; addr_seen = '0;
      for (int i = 0; i < 3; i++) begin
         lat[i] = -1; oe_lo[i] = 0; we_lo[i] = 0; dqoe[i] = 0; ack_n[i] = 0;
      end
      for (int c = 0; c < 20 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            oe_lo[i] += int'(!sram_oe_n_a[i]);
            we_lo[i] += int'(!sram_we_n_a[i]);
            dqoe[i]  += int'(sram_dq_oe_a[i]);
            ack_n[i] += int'(cpu_ack_a[i]);
            if (i == 1 && !sram_we_n_a[1]) begin dq_seen = sram_dq_o_a[1]; addr_seen = sram_addr_a[1]; end
            if (cpu_ack_a[i] && lat[i] < 0) begin lat[i] = c; cpu_req = 1'b0; end
         end
      end
      cpu_req = 1'b0;
   endtask

   initial begin
      int ca, va, k;
      int t [3];
      logic [7:0] vd [3];
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_strobes", {sram_ce_n_a[1], sram_oe_n_a[1], sram_we_n_a[1], sram_dq_oe_a[1]}, 4'b1110);
      chk("rst_addr_dq", {sram_addr_a[1], sram_dq_o_a[1]}, 0);
      chk("rst_acks_busy", {cpu_ack_a[1], vid_ack_a[1], busy_a[1]}, 0);
      chk("rst_rdata", {cpu_rdata_a[1], vid_rdata_a[1]}, 0);

      txn(1'b0, 15'h1234, 8'h00);
      chk("rd_lat", lat[1], 4);
      chk("rd_oe_low", oe_lo[1], 3);
      chk("rd_ack_pulses", ack_n[1], 1);
      chk("rd_data", cpu_rdata_a[1], 8'hA5);
      chk("rd_w0_lat", lat[0], 3);
      chk("rd_w0_oe_low", oe_lo[0], 2);
      chk("rd_w3_lat", lat[2], 6);
      chk("rd_w3_oe_low", oe_lo[2], 5);

      txn(1'b1, 15'h7FFF, 8'h3C);
      chk("wr_lat", lat[1], 4);
      chk("wr_we_low", we_lo[1], 2);
      chk("wr_dq_oe", dqoe[1], 4);
      chk("wr_oe_low", oe_lo[1], 0);
      chk("wr_dq_o", dq_seen, 8'h3C);
      chk("wr_addr", addr_seen, 15'h7FFF);
      chk("wr_rdata_kept", cpu_rdata_a[1], 8'hA5);
      chk("wr_w0_lat", lat[0], 3);
      chk("wr_w0_we_low", we_lo[0], 1);
      chk("wr_w3_lat", lat[2], 6);
      chk("wr_w3_we_low", we_lo[2], 4);

      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0200;
      vid_req = 1'b1; vid_addr = 15'h0355;
      ca = -1; va = -1;
      for (int c = 0; c < 30 && (ca < 0 || va < 0); c++) begin
         @(posedge clk); #1;
         if (cpu_ack_a[1] && ca < 0) begin ca = c; cpu_req = 1'b0; end
         if (vid_ack_a[1] && va < 0) begin va = c; vid_req = 1'b0; end
      end
      cpu_req = 1'b0; vid_req = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      chk("tie_vid_first", va, 4);
      chk("tie_cpu_second", ca, 9);
`else
      chk("tie_cpu_first", ca, 4);
      chk("tie_vid_second", va, 9);
`endif
      chk("tie_cpu_data", cpu_rdata_a[1], 8'h91);
      chk("tie_vid_data", vid_rdata_a[1], 8'hC4);

      vid_req = 1'b1; vid_addr = 15'h0100; k = 0;
      for (int c = 0; c < 40 && k < 3; c++) begin
         @(posedge clk); #1;
         if (vid_ack_a[1]) begin
            t[k] = c; vd[k] = vid_rdata_a[1];
            chk("vid_gap_idle", busy_a[1], 1'b0);
            k++;
            if (k == 3) vid_req = 1'b0;
            else vid_addr = 15'h0100 + 15'(k);
         end
      end
      vid_req = 1'b0;
      chk("vid_count", k, 3);
      if (k == 3) begin
         chk("vid_t0", t[0], 4);
         chk("vid_t1", t[1], 9);
         chk("vid_t2", t[2], 14);
         chk("vid_d0", vd[0], 8'h91);
         chk("vid_d1", vd[1], 8'h90);
         chk("vid_d2", vd[2], 8'h93);
      end

      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0040; cpu_wdata = 8'h77;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_mid_strobe", {sram_we_n_a[1], sram_dq_oe_a[1]}, 2'b01);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_strobes", {sram_ce_n_a[1], sram_oe_n_a[1], sram_we_n_a[1], sram_dq_oe_a[1]}, 4'b1110);
      chk("rst_mid_busy", busy_a[1], 1'b0);
      cpu_req = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      ca = 0;
      repeat (8) begin @(posedge clk); #1; ca += int'(cpu_ack_a[1]); end
      chk("rst_mid_no_ack", ca, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
